// File: rtl/serdes_tx_scheduler_if.sv
// Symbol-slot scheduler bus: framed byte stream in, K-code request in,
// and the registered {K,byte} symbol stream out toward the 8b/10b encoder.
interface serdes_tx_scheduler_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       k_req;
  logic [7:0] k_code;
  logic       k_ack;
  logic [8:0] sym_out;
  logic       sym_strobe;
  logic       underrun;
  logic       in_frame;

  // Source / observer side.
  modport master (
    output s_data, s_valid, s_last, k_req, k_code,
    input  s_ready, k_ack, sym_out, sym_strobe, underrun, in_frame
  );

  // Scheduler side.
  modport slave (
    input  s_data, s_valid, s_last, k_req, k_code,
    output s_ready, k_ack, sym_out, sym_strobe, underrun, in_frame
  );
endinterface

// File: rtl/serdes_tx_scheduler.sv
// Picks one 9-bit {K,byte} symbol per serializer slot: framed data wrapped
// in SOF K27.7 / EOF K29.7, out-of-band K-codes, or K28.5 idle/align/fill
// commas. SYM_BITS must be at least 2.
module serdes_tx_scheduler #(
  parameter int SYM_BITS     = 10,
  parameter int ALIGN_PERIOD = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  serdes_tx_scheduler_if.slave bus
);

  localparam logic [8:0] SYM_COMMA = 9'h1BC;  // K28.5
  localparam logic [8:0] SYM_SOF   = 9'h1FB;  // K27.7
  localparam logic [8:0] SYM_EOF   = 9'h1FD;  // K29.7

  localparam int              CNT_W       = (SYM_BITS > 1) ? $clog2(SYM_BITS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SYM_BITS - 1);
  localparam logic [15:0]      ALIGN_LIMIT = 16'(ALIGN_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_EOF
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] slot_cnt;
  logic [15:0]      align_cnt;
  logic [8:0]       next_sym;
  logic             boundary;
  logic             align_due;
  logic             take_k;
  logic             fill;

  assign boundary  = enable && (slot_cnt == SLOT_LAST);
  assign align_due = (align_cnt >= ALIGN_LIMIT);

  // Handshakes are only offered in the boundary cycle, when the choice is committed.
  assign bus.s_ready = boundary && (state == ST_DATA);
  assign bus.k_ack   = boundary && take_k;

  // Choose this slot's symbol and the successor state; committed only at a boundary.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    next_sym   = SYM_COMMA;
    next_state = state;
    take_k     = 1'b0;
    fill       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (align_due) begin
          next_sym = SYM_COMMA;
        end else if (bus.k_req) begin
          next_sym = {1'b1, bus.k_code};
          take_k   = 1'b1;
        end else if (bus.s_valid) begin
          // SOF only announces the frame; the first byte is taken next slot.
          next_sym   = SYM_SOF;
          next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.s_valid) begin
          next_sym = {1'b0, bus.s_data};
          if (bus.s_last) next_state = ST_EOF;
        end else begin
          fill = 1'b1;
        end
      end
      ST_EOF: begin
        next_sym   = SYM_EOF;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Slot timing, FSM and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt       <= '0;
      align_cnt      <= '0;
      state          <= ST_IDLE;
      bus.sym_out    <= SYM_COMMA;
      bus.sym_strobe <= 1'b0;
      bus.underrun   <= 1'b0;
      bus.in_frame   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      bus.sym_strobe <= boundary;
      bus.underrun   <= boundary && fill;
      if (enable) slot_cnt <= boundary ? '0 : slot_cnt + 1'b1;
      if (boundary) begin
        state        <= next_state;
        bus.sym_out  <= next_sym;
        // Frame flag covers SOF through EOF; it drops with the first symbol after EOF.
        bus.in_frame <= (state != ST_IDLE) || (next_state == ST_DATA);
        if (next_sym == SYM_COMMA)  align_cnt <= '0;
        else if (align_cnt != '1)   align_cnt <= align_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Directed scoreboard bench: the stimulus side pushes the expected symbol of
// each slot, a monitor pops and compares on every sym_strobe.
module tb_serdes_tx_scheduler;

  typedef struct packed {
    logic [8:0] sym;
    logic       und;
    logic       frm;
    logic       rdy;
    logic       ack;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       sel;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       k_req;
  logic [7:0] k_code;

  int   n_vec;
  int   n_err;
  int   rdy_cnt;
  int   ack_cnt;
  int   und_cnt;
  logic prev_rdy;
  logic prev_ack;
  exp_t exp_q[$];

  serdes_tx_scheduler_if bus_a ();
  serdes_tx_scheduler_if bus_b ();

  assign bus_a.s_data  = s_data;
  assign bus_a.s_valid = s_valid;
  assign bus_a.s_last  = s_last;
  assign bus_a.k_req   = k_req;
  assign bus_a.k_code  = k_code;
  assign bus_b.s_data  = s_data;
  assign bus_b.s_valid = s_valid;
  assign bus_b.s_last  = s_last;
  assign bus_b.k_req   = k_req;
  assign bus_b.k_code  = k_code;

  serdes_tx_scheduler #(.SYM_BITS(10), .ALIGN_PERIOD(256)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus_a)
  );

  serdes_tx_scheduler #(.SYM_BITS(10), .ALIGN_PERIOD(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus_b)
  );

  logic [8:0] m_sym;
  logic       m_strobe, m_und, m_frm, m_rdy, m_ack;
  assign m_sym    = sel ? bus_b.sym_out    : bus_a.sym_out;
  assign m_strobe = sel ? bus_b.sym_strobe : bus_a.sym_strobe;
  assign m_und    = sel ? bus_b.underrun   : bus_a.underrun;
  assign m_frm    = sel ? bus_b.in_frame   : bus_a.in_frame;
  assign m_rdy    = sel ? bus_b.s_ready    : bus_a.s_ready;
  assign m_ack    = sel ? bus_b.k_ack      : bus_a.k_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each new slot against the scoreboard; handshakes are
  // taken from the boundary cycle just before the strobe.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_rdy = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (m_strobe) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_strobe: sym_out %h with nothing expected", m_sym);
        end else begin
          e = exp_q.pop_front();
          check("sym_out", 32'(m_sym), 32'(e.sym));
          check("underrun", 32'(m_und), 32'(e.und));
          check("in_frame", 32'(m_frm), 32'(e.frm));
          check("s_ready_at_boundary", 32'(prev_rdy), 32'(e.rdy));
          check("k_ack_at_boundary", 32'(prev_ack), 32'(e.ack));
        end
      end
      if (m_rdy) rdy_cnt++;
      if (m_ack) ack_cnt++;
      if (m_und) und_cnt++;
      prev_rdy = m_rdy;
      prev_ack = m_ack;
    end
  end

  task automatic wait_strobe();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_strobe && n < 40);
    check("strobe_within_budget", 32'(m_strobe), 32'd1);
  endtask

  // Expect one slot with the current inputs, then wait for it to be emitted.
  task automatic slot(input logic [8:0] sym, input logic und, input logic frm,
                      input logic rdy, input logic ack);
    exp_q.push_back('{sym: sym, und: und, frm: frm, rdy: rdy, ack: ack});
    wait_strobe();
  endtask

  initial begin
    int strobe_at[$];
    int c;
    int ack_base;
    n_vec    = 0;
    n_err    = 0;
    rdy_cnt  = 0;
    ack_cnt  = 0;
    und_cnt  = 0;
    prev_rdy = 1'b0;
    prev_ack = 1'b0;
    sel      = 1'b0;
    reset_n  = 1'b0;
    enable   = 1'b1;
    s_data   = 8'h00;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    k_req    = 1'b0;
    k_code   = 8'h00;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_sym_out", 32'(m_sym), 32'h1BC);
    check("reset_strobe", 32'(m_strobe), 32'd0);
    check("reset_in_frame", 32'(m_frm), 32'd0);
    check("reset_underrun", 32'(m_und), 32'd0);

    // Idle: commas only, strobe every 10 cycles, first after the 10th edge.
    repeat (3) exp_q.push_back('{sym: 9'h1BC, und: 1'b0, frm: 1'b0, rdy: 1'b0, ack: 1'b0});
    reset_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (m_strobe) strobe_at.push_back(i);
    end
    check("idle_strobe_count", 32'(strobe_at.size()), 32'd3);
    if (strobe_at.size() == 3) begin
      check("first_strobe_edge", 32'(strobe_at[0]), 32'd10);
      check("second_strobe_edge", 32'(strobe_at[1]), 32'd20);
      check("third_strobe_edge", 32'(strobe_at[2]), 32'd30);
    end
    #1;
    check("idle_ready_count", 32'(rdy_cnt), 32'd0);
    check("idle_ack_count", 32'(ack_cnt), 32'd0);

    // Frame A5,3C,7E with s_valid always high.
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;
    slot(9'h1FB, 1'b0, 1'b1, 1'b0, 1'b0);
    slot(9'h0A5, 1'b0, 1'b1, 1'b1, 1'b0);
    s_data = 8'h3C;
    slot(9'h03C, 1'b0, 1'b1, 1'b1, 1'b0);
    s_data = 8'h7E; s_last = 1'b1;
    slot(9'h07E, 1'b0, 1'b1, 1'b1, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    slot(9'h1FD, 1'b0, 1'b1, 1'b0, 1'b0);
    slot(9'h1BC, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("frame_ready_count", 32'(rdy_cnt), 32'd3);

    // K request together with a pending frame: K-code wins, SOF follows.
    k_req = 1'b1; k_code = 8'h7C; s_valid = 1'b1; s_data = 8'h11; s_last = 1'b1;
    slot(9'h17C, 1'b0, 1'b0, 1'b0, 1'b1);
    k_req = 1'b0;
    slot(9'h1FB, 1'b0, 1'b1, 1'b0, 1'b0);
    slot(9'h011, 1'b0, 1'b1, 1'b1, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    slot(9'h1FD, 1'b0, 1'b1, 1'b0, 1'b0);
    slot(9'h1BC, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two-byte frame with a two-slot gap: fill commas and underrun pulses.
    s_valid = 1'b1; s_data = 8'h5A;
    slot(9'h1FB, 1'b0, 1'b1, 1'b0, 1'b0);
    slot(9'h05A, 1'b0, 1'b1, 1'b1, 1'b0);
    s_valid = 1'b0;
    slot(9'h1BC, 1'b1, 1'b1, 1'b1, 1'b0);
    slot(9'h1BC, 1'b1, 1'b1, 1'b1, 1'b0);
    s_valid = 1'b1; s_data = 8'hC3; s_last = 1'b1;
    slot(9'h0C3, 1'b0, 1'b1, 1'b1, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    slot(9'h1FD, 1'b0, 1'b1, 1'b0, 1'b0);
    slot(9'h1BC, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("underrun_pulse_count", 32'(und_cnt), 32'd2);

    // Enable dropped for 7 cycles mid-slot stretches the slot to 17 cycles.
    s_valid = 1'b1; s_data = 8'h99; s_last = 1'b0;
    exp_q.push_back('{sym: 9'h1FB, und: 1'b0, frm: 1'b1, rdy: 1'b0, ack: 1'b0});
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (c == 3)  enable = 1'b0;
      if (c == 10) enable = 1'b1;
    end while (!m_strobe && c < 60);
    check("stretched_slot_cycles", 32'(c), 32'd17);

    // Reset inside DATA: frame dropped, no EOF, frame re-presented from SOF.
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midframe_reset_sym_out", 32'(m_sym), 32'h1BC);
    check("midframe_reset_in_frame", 32'(m_frm), 32'd0);
    check("midframe_reset_strobe", 32'(m_strobe), 32'd0);
    s_last = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    slot(9'h1FB, 1'b0, 1'b1, 1'b0, 1'b0);
    slot(9'h099, 1'b0, 1'b1, 1'b1, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    slot(9'h1FD, 1'b0, 1'b1, 1'b0, 1'b0);
    slot(9'h1BC, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("total_ready_count", 32'(rdy_cnt), 32'd9);
    check("total_ack_count", 32'(ack_cnt), 32'd1);

    // ALIGN_PERIOD=4 instance with k_req held: forced comma every 4th symbol.
    reset_n = 1'b0;
    sel     = 1'b1;
    k_req   = 1'b1;
    k_code  = 8'hF7;
    repeat (2) @(negedge clk);
    ack_base = ack_cnt;
    reset_n  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      slot(9'h1F7, 1'b0, 1'b0, 1'b0, 1'b1);
      slot(9'h1F7, 1'b0, 1'b0, 1'b0, 1'b1);
      slot(9'h1F7, 1'b0, 1'b0, 1'b0, 1'b1);
      slot(9'h1BC, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    #1;
    check("align_ack_count", 32'(ack_cnt - ack_base), 32'd6);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
